// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline/memory bus bundle for the IF/MEM port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [63:0]       d_rdata;
  logic              d_done;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, err,
           mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  // pipeline stages plus memory model side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, err,
           mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and MEM stages
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int MAX_WAIT   = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int STV_W  = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [STV_W-1:0]  STARVE_MAX = STV_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [STV_W-1:0]  r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [63:0]       r_mem_wdata;
  logic [31:0]       r_if_rdata;
  logic              r_if_done;
  logic [63:0]       r_d_rdata;
  logic              r_d_done;
  logic              r_err;

  logic w_arb_ok;
  logic w_if_win;
  logic w_d_win;
  logic w_timeout;

  // No arbitration in the done cycle: the requester still shows its old req there.
  assign w_arb_ok  = ~r_if_done & ~r_d_done;
  assign w_if_win  = bus.if_req & (~bus.d_req | (r_starve_cnt == STARVE_MAX));
  assign w_d_win   = bus.d_req & ~w_if_win;
  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  // Arbitration, transaction sequencing, timeout and starvation tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_if_done    <= 1'b0;
      r_d_rdata    <= '0;
      r_d_done     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.if_req) r_starve_cnt <= '0;
          if (w_arb_ok && w_if_win) begin
            r_state      <= IF_BUSY;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= bus.if_addr;
            r_mem_wdata  <= bus.d_wdata;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
          end else if (w_arb_ok && w_d_win) begin
            r_state     <= D_BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_wait_cnt  <= '0;
            if (bus.if_req && (r_starve_cnt != STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        IF_BUSY, D_BUSY: begin
          if (bus.mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            if (r_state == IF_BUSY) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= r_mem_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end else begin
              r_d_done <= 1'b1;
              if (!r_mem_we) r_d_rdata <= bus.mem_rdata;
            end
          end else if (w_timeout) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_state == IF_BUSY) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= '0;
            end else begin
              r_d_done <= 1'b1;
              if (!r_mem_we) r_d_rdata <= '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.err       = r_err;
  assign bus.stall_if  = bus.if_req & ~r_if_done;
  assign bus.stall_mem = bus.d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAX_WAIT   = 16;
  localparam int STARVE_LIM = 4;

  logic clk;
  logic reset;
  mem_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] rd; logic err; } exp_t;
  exp_t exp_if_q[$];
  exp_t exp_d_q[$];

  int ncmp = 0;
  int nfail = 0;

  logic [63:0] mdl_mem  [logic [63:0]];
  logic [63:0] resp_mem [logic [63:0]];
  logic [63:0] last_drd = 64'd0;

  int  starve_m = 0;
  bit  resp_en = 1'b1;
  int  d_grants = 0;
  int  if_grants = 0;
  int  last_gap = 0;
  int  last_len = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0] * 32'd3 + 32'd1};
  endfunction

  // Memory latency is encoded in address bits [7:3]: ack arrives that many cycles after mem_req rises.
  function automatic int dly(input logic [63:0] a);
    return int'(a[7:3]);
  endfunction

  function automatic bit timed_out(input logic [63:0] a);
    return dly(a) >= MAX_WAIT;
  endfunction

  function automatic logic [63:0] mdl_rd(input logic [63:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return dflt(a);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_if(input logic [63:0] a);
    exp_t e;
    logic [63:0] w;
    w = mdl_rd({a[63:3], 3'b000});
    e.err = timed_out(a);
    e.rd  = e.err ? 64'd0 : (a[2] ? {32'd0, w[63:32]} : {32'd0, w[31:0]});
    exp_if_q.push_back(e);
  endtask

  task automatic push_d(input logic we, input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    logic [63:0] al;
    al = {a[63:3], 3'b000};
    e.err = timed_out(a);
    if (we) begin
      if (!e.err) mdl_mem[al] = wd;
      e.rd = last_drd;
    end else begin
      e.rd = e.err ? 64'd0 : mdl_rd(al);
      last_drd = e.rd;
    end
    exp_d_q.push_back(e);
  endtask

  task automatic wait_if(input bit keep, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1; lat++;
      if (bus.if_done) begin seen = 1'b1; break; end
    end
    chk("if_done_within_bound", 64'(seen), 64'd1);
    if (!keep) bus.if_req = 1'b0;
  endtask

  task automatic wait_d(input bit keep, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1; lat++;
      if (bus.d_done) begin seen = 1'b1; break; end
    end
    chk("d_done_within_bound", 64'(seen), 64'd1);
    if (!keep) bus.d_req = 1'b0;
  endtask

  task automatic run_if(input logic [63:0] a, input bit keep, output int lat);
    push_if(a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_if(keep, lat);
  endtask

  task automatic run_d(input logic we, input logic [63:0] a, input logic [63:0] wd,
                       input bit keep, output int lat);
    push_d(we, a, wd);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    wait_d(keep, lat);
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return r;
    if (r == 6) return MAX_WAIT - 2;
    if (r == 7) return MAX_WAIT - 1;
    if (r == 8) return MAX_WAIT;
    return $urandom_range(0, 31);
  endfunction

  // Memory model plus grant checker: acks after the address-encoded delay, checks arbitration order.
  initial begin : responder
    bit s_if, s_d, prev_req, is_if, is_d, exp_if_win, lat_we;
    int cnt, low_cnt, exp_len;
    logic [63:0] lat_addr, lat_wdata, al;
    prev_req = 1'b0; cnt = 0; low_cnt = 100; exp_len = 0;
    lat_addr = '0; lat_wdata = '0; lat_we = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      s_if = bus.if_req;
      s_d  = bus.d_req;
      #1;
      if (!s_if) starve_m = 0;
      if (bus.mem_req) begin
        if (!prev_req) begin
          last_gap = low_cnt;
          if (resp_en) begin
            chk("grant_gap", 64'(low_cnt >= 2), 64'd1);
            chk("grant_has_req", 64'(s_if | s_d), 64'd1);
            is_if = s_if && !bus.mem_we && (bus.mem_addr == bus.if_addr);
            is_d  = s_d && (bus.mem_we == bus.d_we) && (bus.mem_addr == bus.d_addr);
            exp_if_win = s_if && (!s_d || starve_m == STARVE_LIM);
            chk("grant_owner", 64'(exp_if_win ? is_if : is_d), 64'd1);
            if (is_d && bus.mem_we) chk("grant_wdata", bus.mem_wdata, bus.d_wdata);
            if (exp_if_win) starve_m = 0;
            else if (s_if) starve_m = (starve_m < STARVE_LIM) ? starve_m + 1 : STARVE_LIM;
            if (is_d) d_grants++;
            if (is_if) if_grants++;
          end
          cnt = 0;
          lat_addr = bus.mem_addr; lat_we = bus.mem_we; lat_wdata = bus.mem_wdata;
          exp_len = timed_out(lat_addr) ? MAX_WAIT : dly(lat_addr) + 1;
        end else begin
          cnt++;
          if (resp_en) begin
            chk("mem_addr_stable", bus.mem_addr, lat_addr);
            chk("mem_wdata_stable", bus.mem_wdata, lat_wdata);
          end
        end
        low_cnt = 0;
        if (resp_en) begin
          if (cnt == dly(lat_addr)) begin
            al = {lat_addr[63:3], 3'b000};
            bus.mem_ack = 1'b1;
            bus.mem_rdata = resp_mem.exists(al) ? resp_mem[al] : dflt(al);
            if (lat_we) resp_mem[al] = lat_wdata;
          end else begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
          end
        end
      end else begin
        if (prev_req && resp_en) begin
          last_len = cnt + 1;
          chk("mem_req_length", 64'(cnt + 1), 64'(exp_len));
        end
        low_cnt++;
        if (resp_en) bus.mem_ack = 1'b0;
      end
      prev_req = bus.mem_req;
    end
  end

  // Scoreboard monitor: pops an expectation whenever a done pulse is presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("stall_if", 64'(bus.stall_if), 64'(bus.if_req & ~bus.if_done));
      chk("stall_mem", 64'(bus.stall_mem), 64'(bus.d_req & ~bus.d_done));
      if (bus.err) chk("err_with_done", 64'(bus.if_done | bus.d_done), 64'd1);
      if (bus.if_done) begin
        if (exp_if_q.size() == 0) chk("if_done_unexpected", 64'(bus.if_done), 64'd0);
        else begin
          e = exp_if_q.pop_front();
          chk("if_rdata", {32'd0, bus.if_rdata}, e.rd);
          chk("if_err", 64'(bus.err), 64'(e.err));
        end
      end
      if (bus.d_done) begin
        if (exp_d_q.size() == 0) chk("d_done_unexpected", 64'(bus.d_done), 64'd0);
        else begin
          e = exp_d_q.pop_front();
          chk("d_rdata", bus.d_rdata, e.rd);
          chk("d_err", 64'(bus.err), 64'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    nfail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, lat2, g0;
    logic [63:0] a;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mdl_mem[64'h100]  = 64'hDEADBEEF_00000013;
    resp_mem[64'h100] = 64'hDEADBEEF_00000013;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with both requests pending
    bus.if_addr = 64'h104; bus.if_req = 1'b1;
    bus.d_addr = 64'h40; bus.d_we = 1'b0; bus.d_req = 1'b1;
    idle(2);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_if_done", 64'(bus.if_done), 64'd0);
    chk("rst_d_done", 64'(bus.d_done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_if_rdata", {32'd0, bus.if_rdata}, 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    push_d(1'b0, 64'h40, 64'd0);
    push_if(64'h104);
    reset = 1'b1;
    chk("mem_req_before_edge", 64'(bus.mem_req), 64'd0);
    idle(1);
    chk("first_grant_req", 64'(bus.mem_req), 64'd1);
    chk("first_grant_addr", bus.mem_addr, 64'h40);
    chk("first_grant_we", 64'(bus.mem_we), 64'd0);
    fork
      wait_d(1'b0, lat);
      wait_if(1'b0, lat2);
    join
    chk("if_after_d_gap", 64'(last_gap), 64'd2);

    // Isolated fetch with immediate ack
    idle(2);
    run_if(64'h104, 1'b0, lat);
    chk("fetch_latency", 64'(lat), 64'd2);

    // Starvation: data held continuously while a fetch waits
    idle(2);
    g0 = d_grants;
    fork
      begin
        for (int i = 0; i < 6; i++)
          run_d(1'b0, 64'h300 + 64'(i * 8), 64'd0, (i < 5), lat);
      end
      begin
        run_if(64'h104, 1'b0, lat2);
        chk("starve_d_grants", 64'(d_grants - g0), 64'd4);
      end
    join

    // Timed-out store, then a normal load
    idle(2);
    run_d(1'b1, 64'h80, 64'hCAFE_F00D_1234_5678, 1'b0, lat);
    idle(1);
    chk("timeout_len", 64'(last_len), 64'(MAX_WAIT));
    run_d(1'b0, 64'h208, 64'd0, 1'b0, lat);

    // Randomized concurrent traffic
    idle(2);
    fork
      begin
        bit k;
        for (int i = 0; i < 30; i++) begin
          a = 64'h1000_0000 | (64'($urandom_range(0, 15)) << 8) | (64'(pick_dly()) << 3)
              | (64'($urandom_range(0, 1)) << 2);
          k = (i < 29) && ($urandom_range(0, 2) == 0);
          run_if(a, k, lat);
          if (!k) idle($urandom_range(0, 3));
        end
      end
      begin
        bit k;
        for (int i = 0; i < 40; i++) begin
          a = 64'h2000_0000 | (64'($urandom_range(0, 3)) << 8) | (64'(pick_dly()) << 3);
          k = (i < 39) && ($urandom_range(0, 2) == 0);
          run_d(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, k, lat);
          if (!k) idle($urandom_range(0, 3));
        end
      end
    join

    // Reset in the middle of a data transaction, late ack afterwards
    idle(2);
    resp_en = 1'b0;
    bus.mem_ack = 1'b0;
    bus.d_addr = 64'h48; bus.d_we = 1'b0; bus.d_req = 1'b1;
    idle(3);
    chk("midrst_busy", 64'(bus.mem_req), 64'd1);
    reset = 1'b0;
    starve_m = 0;
    last_drd = 64'd0;
    #1;
    chk("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("midrst_d_rdata", bus.d_rdata, 64'd0);
    chk("midrst_if_rdata", {32'd0, bus.if_rdata}, 64'd0);
    chk("midrst_mem_addr", bus.mem_addr, 64'd0);
    bus.d_req = 1'b0;
    idle(1);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("midrst_no_done", 64'(bus.d_done), 64'd0);
      chk("midrst_no_req", 64'(bus.mem_req), 64'd0);
    end
    chk("midrst_no_capture", bus.d_rdata, 64'd0);
    bus.mem_ack = 1'b0;
    idle(2);
    resp_en = 1'b1;
    run_d(1'b0, 64'h210, 64'd0, 1'b0, lat);
    idle(3);
    chk("queues_drained", 64'(exp_if_q.size() + exp_d_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
